// File: rtl/rv_pkg.sv
// Shared types and constants for the multi-port register file.
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ZERO     = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves the write ports into one enable/data pair per register index.
// The highest-numbered port wins a collision; index 0 is never enabled.
module regfile_wr_arb
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = 32,
    parameter int NWRITE = 2,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                             i_en,
    input  logic [NWRITE-1:0]                i_wen,
    input  logic [NWRITE-1:0][AW-1:0]        i_wr_sel,
    input  logic [NWRITE-1:0][XLEN-1:0]      i_wr_data,
    output logic [NREGS-1:0]                 o_we,
    output logic [NREGS-1:0][XLEN-1:0]       o_wd
);

    always_comb begin
        o_we = '0;
        o_wd = '0;
        for (int k = REG_ZERO + 1; k < NREGS; k++) begin
            // Ascending port order lets the later port overwrite the earlier one.
            for (int j = 0; j < NWRITE; j++) begin
                if (i_en && i_wen[j] && (i_wr_sel[j] == AW'(k))) begin
                    o_we[k] = 1'b1;
                    o_wd[k] = i_wr_data[j];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads, write-to-read bypass
// and a post-reset clearing walk that zeroes indices 1..NREGS-1.
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    output logic                                   ready,
    input  logic [NREAD-1:0][$clog2(NREGS)-1:0]    rd_sel,
    output logic [NREAD-1:0][XLEN-1:0]             rd_data,
    input  logic [NWRITE-1:0]                      wen,
    input  logic [NWRITE-1:0][$clog2(NREGS)-1:0]   wr_sel,
    input  logic [NWRITE-1:0][XLEN-1:0]            wr_data,
    output state_t                                 o_dbg_state
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ready;
    logic [AW-1:0]       r_clr_idx;
    logic [XLEN-1:0]     r_mem [NREGS];

    logic                w_clear_active;
    logic                w_run;
    logic [NREGS-1:0]            w_we;
    logic [NREGS-1:0][XLEN-1:0]  w_wd;

    // State register; ready is a flop that tracks the state it enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_idx == LAST_IDX) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        w_clear_active = (r_state == ST_CLEAR);
        w_run          = r_ready;
    end

    assign ready       = r_ready;
    assign o_dbg_state = r_state;

    // The walk stops on the last index, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= AW'(1);
        end else if (w_clear_active && (r_clr_idx != LAST_IDX)) begin
            r_clr_idx <= r_clr_idx + AW'(1);
        end
    end

    regfile_wr_arb #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NWRITE (NWRITE),
        .AW     (AW)
    ) u_wr_arb (
        .i_en      (w_run),
        .i_wen     (wen),
        .i_wr_sel  (wr_sel),
        .i_wr_data (wr_data),
        .o_we      (w_we),
        .o_wd      (w_wd)
    );

    // Storage has no reset of its own; it is zeroed only by the clear walk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clear_active) begin
                r_mem[r_clr_idx] <= '0;
            end else begin
                for (int k = 0; k < NREGS; k++) begin
                    if (w_we[k]) r_mem[k] <= w_wd[k];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_data[i] = '0;
            if (w_run && (rd_sel[i] != AW'(REG_ZERO))) begin
                rd_data[i] = w_we[rd_sel[i]] ? w_wd[rd_sel[i]] : r_mem[rd_sel[i]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: clear timing, bypass, port priority,
// register zero, reset during clear/run, and random traffic against a model.
module tb_regfile_mp;
    import rv_pkg::*;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             ready;
    logic [NREAD-1:0][AW-1:0]         rd_sel;
    logic [NREAD-1:0][XLEN-1:0]       rd_data;
    logic [NWRITE-1:0]                wen;
    logic [NWRITE-1:0][AW-1:0]        wr_sel;
    logic [NWRITE-1:0][XLEN-1:0]      wr_data;
    state_t                           dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] model [NREGS];
    logic [XLEN-1:0] exp_q [$];
    int              port_q [$];
    string           tag_q [$];

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .wen         (wen),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input int port, input logic [XLEN-1:0] v);
        exp_q.push_back(v);
        port_q.push_back(port);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        logic [XLEN-1:0] e;
        int p;
        string t;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = port_q.pop_front();
            t = tag_q.pop_front();
            check(t, rd_data[p], e);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen     = '0;
        wr_sel  = '0;
        wr_data = '0;
    endtask

    task automatic set_wr(input int j, input int sel, input logic [XLEN-1:0] d);
        wen[j]     = 1'b1;
        wr_sel[j]  = AW'(sel);
        wr_data[j] = d;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NREGS; k++) model[k] = '0;
    endtask

    // Applies the currently driven writes to the model (call only in RUN, rst low).
    task automatic commit_model();
        for (int j = 0; j < NWRITE; j++) begin
            if (wen[j] && wr_sel[j] != '0) model[wr_sel[j]] = wr_data[j];
        end
    endtask

    function automatic logic [XLEN-1:0] byp_exp(input logic [AW-1:0] s);
        logic [XLEN-1:0] r;
        if (s == '0) return '0;
        r = model[s];
        for (int j = 0; j < NWRITE; j++) begin
            if (wen[j] && wr_sel[j] == s) r = wr_data[j];
        end
        return r;
    endfunction

    task automatic measure_clear(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic read_all_model(input string tag);
        for (int r = 0; r < NREGS; r++) begin
            rd_sel[0] = AW'(r);
            rd_sel[1] = AW'(NREGS - 1 - r);
            expect_rd(tag, 0, model[r]);
            expect_rd(tag, 1, model[NREGS - 1 - r]);
            drain();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int n_pre;
        idle();
        rst    = 1'b1;
        rd_sel = '0;
        rd_sel[0] = AW'(5);
        clear_model();

        // Reset for one edge, then the clear walk must take 31 edges.
        step();
        expect_rd("rst_rd0", 0, '0);
        expect_rd("rst_rd1", 1, '0);
        drain();
        check("rst_ready", ready, '0);
        rst = 1'b0;
        measure_clear(n);
        check("clear_len", n, 31);
        check("state_run", dbg_state, ST_RUN);
        read_all_model("post_clear_zero");

        // Bypass then stored on a single write.
        step();
        set_wr(0, 5, 32'hDEADBEEF);
        rd_sel[0] = AW'(5);
        rd_sel[1] = AW'(5);
        expect_rd("byp5_p0", 0, 32'hDEADBEEF);
        expect_rd("byp5_p1", 1, byp_exp(AW'(5)));
        drain();
        commit_model();
        step();
        idle();
        expect_rd("st5_p0", 0, 32'hDEADBEEF);
        drain();

        // Same index on both ports: port 1 wins.
        step();
        set_wr(0, 7, 32'h11);
        set_wr(1, 7, 32'h22);
        rd_sel[0] = AW'(7);
        rd_sel[1] = AW'(7);
        expect_rd("byp7_p0", 0, 32'h22);
        expect_rd("byp7_p1", 1, 32'h22);
        drain();
        commit_model();
        step();
        idle();
        expect_rd("st7_p0", 0, 32'h22);
        drain();

        // Register zero ignores writes.
        step();
        set_wr(0, 0, 32'hFFFFFFFF);
        set_wr(1, 0, 32'h12345678);
        rd_sel[0] = '0;
        rd_sel[1] = '0;
        expect_rd("byp0_p0", 0, '0);
        expect_rd("byp0_p1", 1, '0);
        drain();
        commit_model();
        step();
        idle();
        expect_rd("st0_p0", 0, '0);
        drain();

        // Distinct indices commit together.
        step();
        set_wr(0, 4, 32'h1);
        set_wr(1, 9, 32'h2);
        rd_sel[0] = AW'(4);
        rd_sel[1] = AW'(9);
        expect_rd("byp4", 0, 32'h1);
        expect_rd("byp9", 1, 32'h2);
        drain();
        commit_model();
        step();
        idle();
        expect_rd("st4", 0, 32'h1);
        expect_rd("st9", 1, 32'h2);
        drain();

        // Random traffic with frequent collisions on low indices.
        for (int c = 0; c < 60; c++) begin
            step();
            for (int j = 0; j < NWRITE; j++) begin
                wen[j]     = 1'($urandom_range(0, 1));
                wr_sel[j]  = AW'($urandom_range(0, (c % 2) ? 7 : NREGS - 1));
                wr_data[j] = $urandom;
            end
            for (int i = 0; i < NREAD; i++) begin
                rd_sel[i] = ($urandom_range(0, 1) == 1) ? wr_sel[i % NWRITE]
                                                        : AW'($urandom_range(0, NREGS - 1));
                expect_rd("rand_rd", i, byp_exp(rd_sel[i]));
            end
            drain();
            commit_model();
        end
        step();
        idle();
        read_all_model("rand_readback");

        // Index 3 holds 0xA5, then reset is held for two edges in RUN.
        step();
        set_wr(0, 3, 32'hA5);
        rd_sel[0] = AW'(3);
        drain();
        commit_model();
        step();
        idle();
        expect_rd("st3", 0, 32'hA5);
        drain();
        step();
        set_wr(0, 3, 32'h5A);
        rst = 1'b1;
        step();
        idle();
        for (int h = 0; h < 2; h++) begin
            rd_sel[0] = AW'(3);
            rd_sel[1] = AW'(9);
            expect_rd("rst_hold_rd0", 0, '0);
            expect_rd("rst_hold_rd1", 1, '0);
            drain();
            check("rst_hold_ready", ready, '0);
            if (h == 0) step();
        end
        rst = 1'b0;
        clear_model();

        // Ten clear edges with reads forced to zero, then reset pulses again.
        for (int k = 0; k < 10; k++) begin
            step();
            expect_rd("clear_rd3", 0, '0);
            expect_rd("clear_rd9", 1, '0);
            drain();
            check("clear_ready", ready, '0);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // A write issued during the restarted clear must be lost.
        set_wr(0, 2, 32'h77);
        step();
        idle();
        n_pre = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_pre++;
        end
        measure_clear(n);
        check("clear_len_restart", n_pre + n, 31);
        step();
        rd_sel[0] = AW'(3);
        rd_sel[1] = AW'(2);
        expect_rd("after_rst_rd3", 0, '0);
        expect_rd("lost_wr_rd2", 1, '0);
        drain();
        read_all_model("after_rst_all");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
